// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM state encoding,
// command/data frame sizes and the default identity byte.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } spi_slv_state_t;

    localparam logic       MPU_MODE_R       = 1'b1;
    localparam int         CMD_BITS         = 8;
    localparam int         DATA_BITS        = 8;
    localparam logic [7:0] WHO_AM_I_DEFAULT = 8'h68;

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pin bundle between a master and the responder. There is no handshake:
// the master owns sclk/cs/mosi, the responder drives miso and its pad enable.
interface spi_slave_responder_if;

    logic sclk;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a history flop that
// turns the synchronized level into single-cycle rise and fall events.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-3 SPI responder: decodes an R/W + 7-bit address command, then streams
// bytes with address auto-increment into or out of a small register file.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int         REG_NUM     = 16,
    parameter int         RO_NUM      = 6,
    parameter logic [7:0] WHO_AM_I    = WHO_AM_I_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spi_slave_responder_if.slave spi,
    input  logic [8*RO_NUM-1:0]  sensor_data_i,
    output logic                 reg_wr_o,
    output logic [6:0]           reg_addr_o,
    output logic [7:0]           reg_wdata_o,
    output logic                 busy_o,
    output spi_slv_state_t       state_o
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_slv_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [6:0] addr;
    logic       miso_q;
    logic       miso_oe_q;
    logic [7:0] regs [RO_NUM+1:REG_NUM-1];

    logic [7:0] rx_next;
    logic [6:0] load_addr;
    logic [7:0] load_byte;
    logic       wr_hit;
    logic       last_bit;

    // SCLK idles high, so its synchronizer resets high to avoid a phantom edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk   (clk_i),
        .rst_n (rst_i),
        .din   (spi.sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk   (clk_i),
        .rst_n (rst_i),
        .din   (spi.cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI gets the same depth as SCLK so data and clock stay aligned.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.mosi};
        end
    end

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign rx_next  = {rx_shift[6:0], mosi_s};
    assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));
    assign wr_hit   = (int'(addr) > RO_NUM) && (int'(addr) < REG_NUM);

    // Address of the byte about to be loaded: the command's address on entry
    // to RD_DATA, otherwise the next address of the burst.
    assign load_addr = (state == CMD) ? rx_next[6:0] : addr + 7'd1;

    always_comb begin
        load_byte = 8'h00;
        if (load_addr == 7'd0) begin
            load_byte = WHO_AM_I;
        end
        for (int k = 0; k < RO_NUM; k++) begin
            if (int'(load_addr) == k + 1) begin
                load_byte = sensor_data_i[k*8 +: 8];
            end
        end
        for (int k = RO_NUM + 1; k < REG_NUM; k++) begin
            if (int'(load_addr) == k) begin
                load_byte = regs[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            addr        <= 7'd0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            reg_wr_o    <= 1'b0;
            reg_addr_o  <= 7'd0;
            reg_wdata_o <= 8'h00;
            for (int k = RO_NUM + 1; k < REG_NUM; k++) begin
                regs[k] <= 8'h00;
            end
        end else begin
            reg_wr_o <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_rise) begin
                        bit_cnt  <= 3'd0;
                        rx_shift <= 8'h00;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(CMD_BITS - 1)) begin
                            bit_cnt <= 3'd0;
                            addr    <= rx_next[6:0];
                            if (rx_next[7] == MPU_MODE_R) begin
                                tx_shift  <= load_byte;
                                miso_oe_q <= 1'b1;
                                state     <= RD_DATA;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (sclk_fall) begin
                        miso_q   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            bit_cnt  <= 3'd0;
                            addr     <= addr + 7'd1;
                            tx_shift <= load_byte;
                        end
                    end
                end
                WR_DATA: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            bit_cnt <= 3'd0;
                            addr    <= addr + 7'd1;
                            if (wr_hit) begin
                                reg_wr_o    <= 1'b1;
                                reg_addr_o  <= addr;
                                reg_wdata_o <= rx_next;
                            end
                            for (int k = RO_NUM + 1; k < REG_NUM; k++) begin
                                if (int'(addr) == k) begin
                                    regs[k] <= rx_next;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A byte finishing in the same cycle as CS falling still lands
            // above; the abort below only discards partial bytes.
            if (state != IDLE && cs_fall) begin
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign busy_o      = cs_level;
    assign state_o     = state;

    logic unused_sclk_level;
    assign unused_sclk_level = sclk_level;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a bit-banged mode-3 master with
// hand-computed expected bytes, strobe counts and output-enable masks.
module tb_spi_slave_responder;
    import spi_pkg::*;

    localparam int HALF = 8;

    logic           clk;
    logic           rst;
    logic [47:0]    sensor;
    logic           reg_wr;
    logic [6:0]     reg_addr;
    logic [7:0]     reg_wdata;
    logic           busy;
    spi_slv_state_t dut_state;

    int vectors;
    int miscompares;
    int wr_cnt;
    logic [6:0] last_addr;
    logic [7:0] last_data;

    spi_slave_responder_if bus ();

    spi_slave_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi           (bus),
        .sensor_data_i (sensor),
        .reg_wr_o      (reg_wr),
        .reg_addr_o    (reg_addr),
        .reg_wdata_o   (reg_wdata),
        .busy_o        (busy),
        .state_o       (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle the strobe is high, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = reg_addr;
            last_data = reg_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx, output logic [7:0] oe);
        rx = 8'h00;
        oe = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.sclk = 1'b0;
            bus.mosi = tx[i];
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b1;
            rx[i] = bus.miso;
            oe[i] = bus.miso_oe;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic cs_begin();
        bus.cs = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] oe;
        int wr_base;

        vectors     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        last_addr   = 7'd0;
        last_data   = 8'h00;
        rst         = 1'b0;
        bus.sclk    = 1'b1;
        bus.cs      = 1'b0;
        bus.mosi    = 1'b0;
        sensor      = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

        // Reset
        repeat (2) @(negedge clk);
        check("rst miso", bus.miso, 1'b0);
        check("rst miso_oe", bus.miso_oe, 1'b0);
        check("rst reg_wr", reg_wr, 1'b0);
        check("rst reg_addr", reg_addr, 7'd0);
        check("rst reg_wdata", reg_wdata, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst state", dut_state, IDLE);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        cs_begin();
        check("busy high", busy, 1'b1);
        xfer(8'h88, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_end();
        check("rst reg08", rx, 8'h00);
        check("busy low", busy, 1'b0);

        // WHO_AM_I
        cs_begin();
        xfer(8'h80, 8, rx, oe);
        check("who cmd oe", oe, 8'h00);
        xfer(8'h00, 8, rx, oe);
        check("who data", rx, 8'h68);
        check("who data oe", oe, 8'hFF);
        cs_end();
        check("who oe after cs", bus.miso_oe, 1'b0);
        check("who miso after cs", bus.miso, 1'b0);

        // Write 0x0A then read it back
        wr_base = wr_cnt;
        cs_begin();
        xfer(8'h0A, 8, rx, oe);
        xfer(8'h5C, 8, rx, oe);
        check("wr oe", oe, 8'h00);
        cs_end();
        check("wr strobes", wr_cnt - wr_base, 1);
        check("wr addr", last_addr, 7'h0A);
        check("wr data", last_data, 8'h5C);
        cs_begin();
        xfer(8'h8A, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_end();
        check("rd 0A", rx, 8'h5C);

        // Burst read of the read-only sensor image
        cs_begin();
        xfer(8'h81, 8, rx, oe);
        for (int i = 1; i <= 6; i++) begin
            xfer(8'h00, 8, rx, oe);
            check($sformatf("burst byte %0d", i), rx, 8'(i));
            check($sformatf("burst oe %0d", i), oe, 8'hFF);
        end
        cs_end();

        // Protected write to a read-only register
        wr_base = wr_cnt;
        cs_begin();
        xfer(8'h03, 8, rx, oe);
        xfer(8'hFF, 8, rx, oe);
        cs_end();
        check("ro wr strobes", wr_cnt - wr_base, 0);
        cs_begin();
        xfer(8'h83, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_end();
        check("ro rd 03", rx, 8'h03);

        // Burst write at 0x7F wraps to 0x00; both bytes dropped
        wr_base = wr_cnt;
        cs_begin();
        xfer(8'h7F, 8, rx, oe);
        xfer(8'hAA, 8, rx, oe);
        xfer(8'hBB, 8, rx, oe);
        cs_end();
        check("wrap wr strobes", wr_cnt - wr_base, 0);
        cs_begin();
        xfer(8'hFF, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        check("wrap rd 7F", rx, 8'h00);
        xfer(8'h00, 8, rx, oe);
        check("wrap rd 00", rx, 8'h68);
        cs_end();

        // Burst write across the top of the register file
        wr_base = wr_cnt;
        cs_begin();
        xfer(8'h0E, 8, rx, oe);
        xfer(8'h11, 8, rx, oe);
        xfer(8'h22, 8, rx, oe);
        xfer(8'h33, 8, rx, oe);
        cs_end();
        check("top wr strobes", wr_cnt - wr_base, 2);
        check("top last addr", last_addr, 7'h0F);
        check("top last data", last_data, 8'h22);
        cs_begin();
        xfer(8'h8E, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        check("top rd 0E", rx, 8'h11);
        xfer(8'h00, 8, rx, oe);
        check("top rd 0F", rx, 8'h22);
        xfer(8'h00, 8, rx, oe);
        check("top rd 10", rx, 8'h00);
        cs_end();

        // Abort after 5 data bits of a write
        wr_base = wr_cnt;
        cs_begin();
        xfer(8'h0A, 8, rx, oe);
        xfer(8'hA5, 5, rx, oe);
        cs_end();
        check("abort strobes", wr_cnt - wr_base, 0);
        check("abort state", dut_state, IDLE);
        cs_begin();
        xfer(8'h8A, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_end();
        check("abort rd 0A", rx, 8'h5C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
